// File: rtl/lzc_pipe.sv
// lzc_pipe: pipelined leading/trailing zero/one run counter with a valid/ready stream
module lzc_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic [WIDTH-1:0]           Num,
    input  logic [1:0]                 Mode,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic [$clog2(WIDTH+1)-1:0] ZeroCnt,
    output logic                       AllMatch
);
    localparam int L  = $clog2(WIDTH);
    localparam int P  = 1 << L;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int SN = (STAGES > 0) ? STAGES : 1;

    function automatic int stage_at(input int k);
        int r;
        r = -1;
        for (int s = 0; s < STAGES; s++)
            if (((s + 1) * L) / STAGES == k) r = s;
        return r;
    endfunction

    logic [WIDTH-1:0] w_inv;
    logic [WIDTH-1:0] w_pre;
    logic [L:0]       w_top;

    assign w_inv = Num ^ {WIDTH{Mode[0]}};

    // trailing modes bit-reverse so the tree only ever counts leading zeros
    always_comb
        for (int i = 0; i < WIDTH; i++) w_pre[i] = Mode[1] ? w_inv[WIDTH-1-i] : w_inv[i];

    if (STAGES > 0) begin : g_ctl
        logic [SN-1:0] r_v;
        logic [SN-1:0] w_ld;
        logic [SN-1:0] w_nx;
        assign w_nx = SN'({r_v, InValid});
        // a stage loads when it or any later stage is empty, or the consumer takes the result
        always_comb
            for (int s = 0; s < SN; s++) w_ld[s] = OutReady | ~&(r_v | SN'((1 << s) - 1));
        // valid bits advance with their data; a held stage keeps its valid
        always_ff @(posedge clk)
            if (reset) r_v <= '0;
            else r_v <= (w_ld & w_nx) | (~w_ld & r_v);
        assign InReady  = w_ld[0];
        assign OutValid = r_v[SN-1];
    end else begin : g_comb
        assign InReady  = OutReady;
        assign OutValid = InValid;
    end

    genvar k, j;
    for (k = 0; k <= L; k++) begin : g_lv
        localparam int N = P >> k;
        localparam int S = stage_at(k);
        logic [k:0] w_n [N];
        logic [k:0] w_o [N];
        for (j = 0; j < N; j++) begin : g_nd
            if (k == 0) begin : g_leaf
                if (j < WIDTH) begin : g_bit
                    assign w_n[j] = ~w_pre[WIDTH-1-j];
                end else begin : g_pad
                    assign w_n[j] = 1'b0;
                end
            end else begin : g_join
                logic [k-1:0] w_l;
                logic [k-1:0] w_r;
                assign w_l    = g_lv[k-1].w_o[2*j];
                assign w_r    = g_lv[k-1].w_o[2*j+1];
                assign w_n[j] = w_l[k-1] ? {1'b0, w_l} + {1'b0, w_r} : {1'b0, w_l};
            end
        end
        if (S >= 0) begin : g_reg
            logic [k:0] r_n [N];
            // capture this tree level whenever its stage loads
            always_ff @(posedge clk)
                if (reset) r_n <= '{default: '0};
                else if (g_ctl.w_ld[S]) r_n <= w_n;
            assign w_o = r_n;
        end else begin : g_wire
            assign w_o = w_n;
        end
    end

    assign w_top    = g_lv[L].w_o[0];
    assign ZeroCnt  = CW'(w_top);
    assign AllMatch = (w_top == (L + 1)'(WIDTH));
endmodule

// File: tb/tb_lzc_pipe.sv
// tb_lzc_pipe: self-checking bench for lzc_pipe (32-bit/2-stage and 5-bit/combinational)
module tb_lzc_pipe;
    logic clk = 0;
    logic reset = 1;
    always #5 clk = ~clk;

    logic        in_valid = 1, out_ready = 1, in_ready, out_valid, all_match;
    logic [31:0] num = 0;
    logic [1:0]  mode = 0;
    logic [5:0]  zero_cnt;

    logic       iv5 = 0, or5 = 0, ir5, ov5, am5;
    logic [4:0] num5 = 0;
    logic [1:0] mode5 = 0;
    logic [2:0] zc5;

    lzc_pipe #(.WIDTH(32), .STAGES(2)) dut (
        .clk(clk), .reset(reset), .InValid(in_valid), .InReady(in_ready), .Num(num),
        .Mode(mode), .OutValid(out_valid), .OutReady(out_ready), .ZeroCnt(zero_cnt),
        .AllMatch(all_match));

    lzc_pipe #(.WIDTH(5), .STAGES(0)) dut5 (
        .clk(clk), .reset(reset), .InValid(iv5), .InReady(ir5), .Num(num5),
        .Mode(mode5), .OutValid(ov5), .OutReady(or5), .ZeroCnt(zc5), .AllMatch(am5));

    int errs = 0, checks = 0;
    int cyc = 0, n_out = 0, first_out = -1, last_out = -1;

    typedef struct { int cnt; bit all; } exp_t;
    exp_t q[$];

    typedef struct { logic [31:0] num; logic [1:0] mode; int cnt; bit all; } vec_t;
    vec_t tbl[12];

    typedef struct { logic [4:0] num; logic [1:0] mode; int cnt; bit all; } vec5_t;
    vec5_t tbl5[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_cnt(input logic [31:0] n, input logic [1:0] m, input int w);
        int  c = 0;
        bit  done = 0;
        for (int i = 0; i < w; i++) begin
            int b;
            b = m[1] ? i : w - 1 - i;
            if (!done && n[b] == m[0]) c++;
            else done = 1;
        end
        return c;
    endfunction

    always @(negedge clk) begin
        int c;
        cyc++;
        if (reset) q.delete();
        else begin
            if (out_valid) begin
                if (q.size() == 0) chk("spurious_out", out_valid, 0);
                else begin
                    chk("sb_zcnt", zero_cnt, q[0].cnt);
                    chk("sb_allm", all_match, q[0].all);
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                        if (first_out < 0) first_out = cyc;
                        last_out = cyc;
                    end
                end
            end
            if (in_valid && in_ready) begin
                c = ref_cnt(num, mode, 32);
                q.push_back('{cnt: c, all: (c == 32)});
            end
        end
    end

    task automatic run_one(input logic [31:0] n, input logic [1:0] m, input int cnt, input bit all,
                           input string name);
        int lat = 0;
        in_valid = 1;
        num = n;
        mode = m;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) in_valid = 0;
        end while (!out_valid && lat < 10);
        chk({name, "_lat"}, lat, 2);
        chk({name, "_cnt"}, zero_cnt, cnt);
        chk({name, "_all"}, all_match, all);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int acc;
        tbl = '{'{32'h0001_0000, 2'b00, 15, 0}, '{32'h0001_0000, 2'b10, 16, 0},
                '{32'h0001_0000, 2'b01, 0, 0},  '{32'h0001_0000, 2'b11, 0, 0},
                '{32'h0000_0000, 2'b00, 32, 1}, '{32'hFFFF_FFFF, 2'b01, 32, 1},
                '{32'h8000_0000, 2'b00, 0, 0},  '{32'h0000_0000, 2'b10, 32, 1},
                '{32'hFFFF_FFFF, 2'b11, 32, 1}, '{32'hF000_0000, 2'b01, 4, 0},
                '{32'h0000_0007, 2'b11, 3, 0},  '{32'h0000_0001, 2'b00, 31, 0}};
        tbl5 = '{'{5'b00101, 2'b00, 2, 0}, '{5'b00000, 2'b00, 5, 1}, '{5'b11111, 2'b01, 5, 1},
                 '{5'b00100, 2'b10, 2, 0}, '{5'b10111, 2'b11, 3, 0}, '{5'b01111, 2'b01, 0, 0}};

        // reset held two cycles with an operand presented
        @(posedge clk); #1;
        chk("rst_ovalid", out_valid, 0);
        chk("rst_zcnt", zero_cnt, 0);
        chk("rst_allm", all_match, 0);
        @(posedge clk); #1;
        reset = 0;
        chk("post_rst_inready", in_ready, 1);
        run_one(32'h0, 2'b00, 32, 1, "rst_first");

        foreach (tbl[i]) run_one(tbl[i].num, tbl[i].mode, tbl[i].cnt, tbl[i].all, $sformatf("vec%0d", i));

        // back-to-back stream at full throughput
        repeat (3) @(posedge clk);
        #1;
        n_out = 0;
        first_out = -1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1;
            num = $urandom;
            mode = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
        end
        in_valid = 0;
        repeat (6) @(posedge clk);
        #1;
        chk("stream_count", n_out, 8);
        chk("stream_consec", last_out - first_out + 1, 8);
        chk("stream_drain", q.size(), 0);

        // consumer stall: pipeline fills, outputs held, then drains in order
        n_out = 0;
        acc = 0;
        out_ready = 0;
        in_valid = 1;
        num = $urandom;
        mode = 2'($urandom_range(0, 3));
        for (int c = 0; c < 5; c++) begin
            bit a;
            @(negedge clk);
            a = in_valid && in_ready;
            if (a) acc++;
            @(posedge clk); #1;
            if (a) begin
                num = $urandom;
                mode = 2'($urandom_range(0, 3));
            end
        end
        chk("stall_accepts", acc, 2);
        chk("stall_inready", in_ready, 0);
        chk("stall_no_out", n_out, 0);
        in_valid = 0;
        out_ready = 1;
        repeat (6) @(posedge clk);
        #1;
        chk("stall_drain_n", n_out, 2);
        chk("stall_q_empty", q.size(), 0);

        // reset with two operands in flight discards them
        out_ready = 0;
        in_valid = 1;
        num = 32'h0000_00F0;
        @(posedge clk); #1;
        num = 32'h0F00_0000;
        @(posedge clk); #1;
        in_valid = 0;
        reset = 1;
        @(posedge clk); #1;
        chk("midrst_ovalid", out_valid, 0);
        reset = 0;
        out_ready = 1;
        n_out = 0;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_out", n_out, 0);

        // combinational 5-bit instance
        foreach (tbl5[i]) begin
            iv5 = 1;
            or5 = i[0];
            num5 = tbl5[i].num;
            mode5 = tbl5[i].mode;
            #1;
            chk($sformatf("w5_cnt%0d", i), zc5, tbl5[i].cnt);
            chk($sformatf("w5_all%0d", i), am5, tbl5[i].all);
            chk($sformatf("w5_ready%0d", i), ir5, i % 2);
        end
        iv5 = 0;
        #1;
        chk("w5_ovalid_lo", ov5, 0);
        iv5 = 1;
        #1;
        chk("w5_ovalid_hi", ov5, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
